// File: rtl/cplx_peak_select.sv
// Purpose: per-burst peak-magnitude select and energy sum over complex samples.
// Latency: out_valid rises 2 edges after the edge sampling the last burst sample.
// Backpressure: record held stable until out_ready; samples arriving meanwhile are dropped and flagged.
module cplx_peak_select #(
    parameter int W         = 14,
    parameter int BURST_LEN = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic signed [W-1:0]   in_real,
    input  logic signed [W-1:0]   in_image,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [1:0]            peak_idx,
    output logic signed [W-1:0]   peak_real,
    output logic signed [W-1:0]   peak_image,
    output logic [2*W-1:0]        peak_mag,
    output logic [2*W+1:0]        sum_mag,
    output logic                  ovf_err,
    output logic                  frag_err
);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, HOLD} state_t;

    localparam logic [2:0] LAST_IDX = 3'(BURST_LEN - 1);

    state_t state, state_nxt;

    logic [2:0] cnt;        // index of the next sample within the burst
    logic       drain_cnt;  // second DRAIN cycle marker
    logic       skip;       // ignoring the remainder of a dropped burst

    logic accept, start, capture, frag, drop;

    // stage 1: registered sample
    logic                 s1_vld;
    logic [1:0]           s1_idx;
    logic signed [W-1:0]  s1_re, s1_im;
    // stage 2: registered magnitude
    logic                 s2_vld;
    logic [1:0]           s2_idx;
    logic signed [W-1:0]  s2_re, s2_im;
    logic [2*W-1:0]       s2_mag;

    logic signed [2*W-1:0] sq_re, sq_im;
    logic [2*W-1:0]        mag_nxt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: begin
                if (!in_valid)             state_nxt = IDLE;
                else if (cnt == LAST_IDX)  state_nxt = DRAIN;
            end
            DRAIN:   if (drain_cnt) state_nxt = HOLD;
            HOLD:    if (accept) state_nxt = start ? COLLECT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and control strobe decode; a burst may begin on the acceptance edge.
    always_comb begin
        out_valid = (state == HOLD);
        accept    = (state == HOLD) && out_ready;
        start     = in_valid && !skip && ((state == IDLE) || accept);
        capture   = start || ((state == COLLECT) && in_valid);
        frag      = (state == COLLECT) && !in_valid;
        drop      = in_valid && ((state == DRAIN) || ((state == HOLD) && !out_ready));
    end

    // Burst counter, drain timer, drop-skip tracking and sticky error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            drain_cnt <= 1'b0;
            skip      <= 1'b0;
            ovf_err   <= 1'b0;
            frag_err  <= 1'b0;
        end else begin
            if (start)                             cnt <= 3'd1;
            else if ((state == COLLECT) && in_valid) cnt <= cnt + 3'd1;
            else                                   cnt <= '0;

            drain_cnt <= (state == DRAIN) && !drain_cnt;

            if (drop)           skip <= 1'b1;
            else if (!in_valid) skip <= 1'b0;

            ovf_err  <= ovf_err  | drop;
            frag_err <= frag_err | frag;
        end
    end

    // Stage 1: capture the accepted sample with its burst index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_idx <= '0;
            s1_re  <= '0;
            s1_im  <= '0;
        end else begin
            s1_vld <= capture;
            if (capture) begin
                s1_idx <= start ? 2'd0 : cnt[1:0];
                s1_re  <= in_real;
                s1_im  <= in_image;
            end
        end
    end

    // Magnitude squared; the sum peaks at 2^(2W-1) so 2W bits never overflow.
    always_comb begin
        sq_re   = s1_re * s1_re;
        sq_im   = s1_im * s1_im;
        mag_nxt = $unsigned(sq_re) + $unsigned(sq_im);
    end

    // Stage 2: register the magnitude; a fragment kills in-flight samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_idx <= '0;
            s2_re  <= '0;
            s2_im  <= '0;
            s2_mag <= '0;
        end else begin
            s2_vld <= s1_vld && !frag;
            if (s1_vld) begin
                s2_idx <= s1_idx;
                s2_re  <= s1_re;
                s2_im  <= s1_im;
                s2_mag <= mag_nxt;
            end
        end
    end

    // Stage 3: peak compare (strictly greater wins) and energy accumulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_idx   <= '0;
            peak_real  <= '0;
            peak_image <= '0;
            peak_mag   <= '0;
            sum_mag    <= '0;
        end else if (frag || accept) begin
            peak_idx   <= '0;
            peak_real  <= '0;
            peak_image <= '0;
            peak_mag   <= '0;
            sum_mag    <= '0;
        end else if (s2_vld) begin
            if ((s2_idx == 2'd0) || (s2_mag > peak_mag)) begin
                peak_idx   <= s2_idx;
                peak_real  <= s2_re;
                peak_image <= s2_im;
                peak_mag   <= s2_mag;
            end
            if (s2_idx == 2'd0) sum_mag <= {2'b00, s2_mag};
            else                sum_mag <= sum_mag + {2'b00, s2_mag};
        end
    end

endmodule

// File: tb/tb_cplx_peak_select.sv
module tb_cplx_peak_select;

    localparam int W = 14;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic signed [W-1:0]  in_real = '0;
    logic signed [W-1:0]  in_image = '0;
    logic                 out_ready = 1'b0;
    logic                 out_valid;
    logic [1:0]           peak_idx;
    logic signed [W-1:0]  peak_real;
    logic signed [W-1:0]  peak_image;
    logic [2*W-1:0]       peak_mag;
    logic [2*W+1:0]       sum_mag;
    logic                 ovf_err;
    logic                 frag_err;

    cplx_peak_select #(.W(W), .BURST_LEN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_real    (in_real),
        .in_image   (in_image),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .peak_idx   (peak_idx),
        .peak_real  (peak_real),
        .peak_image (peak_image),
        .peak_mag   (peak_mag),
        .sum_mag    (sum_mag),
        .ovf_err    (ovf_err),
        .frag_err   (frag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int     idx;
        int     re;
        int     im;
        longint mag;
        longint sum;
    } rec_t;

    rec_t   exp_q[$];
    rec_t   mon_rec;
    rec_t   held;
    int     br[3];
    int     bi[3];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input rec_t e);
        check({tag, "_idx"},  longint'(peak_idx), longint'(e.idx));
        check({tag, "_re"},   longint'(peak_real), longint'(e.re));
        check({tag, "_im"},   longint'(peak_image), longint'(e.im));
        check({tag, "_mag"},  longint'(peak_mag), e.mag);
        check({tag, "_sum"},  longint'(sum_mag), e.sum);
    endtask

    // Reference: first sample seeds the peak, later ones replace it only when strictly larger.
    function automatic rec_t model();
        rec_t   r;
        longint m;
        r.idx = 0; r.re = 0; r.im = 0; r.mag = 0; r.sum = 0;
        for (int k = 0; k < 3; k++) begin
            m = longint'(br[k]) * br[k] + longint'(bi[k]) * bi[k];
            if (k == 0 || m > r.mag) begin
                r.idx = k; r.re = br[k]; r.im = bi[k]; r.mag = m;
            end
            r.sum += m;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input int r, input int i);
        in_valid = 1'b1;
        in_real  = W'(r);
        in_image = W'(i);
        step();
    endtask

    task automatic burst(input int r0, input int i0, input int r1, input int i1,
                         input int r2, input int i2, input int n, input bit push);
        br[0] = r0; br[1] = r1; br[2] = r2;
        bi[0] = i0; bi[1] = i1; bi[2] = i2;
        for (int k = 0; k < n; k++) send(br[k], bi[k]);
        in_valid = 1'b0;
        in_real  = '0;
        in_image = '0;
        if (push) exp_q.push_back(model());
    endtask

    // Scoreboard: every accepted record is compared with the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", 1, 0);
            end else begin
                mon_rec = exp_q.pop_front();
                check_outputs("rec", mon_rec);
            end
        end
    end

    initial begin
        #12;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_peak_idx",  longint'(peak_idx), 0);
        check("rst_peak_mag",  longint'(peak_mag), 0);
        check("rst_sum_mag",   longint'(sum_mag), 0);
        check("rst_ovf",       longint'(ovf_err), 0);
        check("rst_frag",      longint'(frag_err), 0);
        rst = 1'b0;
        step();

        // Tie-break and latency
        out_ready = 1'b1;
        burst(3, 4, -5, 0, 1, -1, 3, 1'b1);
        step();
        check("lat_e1_valid", longint'(out_valid), 0);
        step();
        check("lat_e2_valid", longint'(out_valid), 1);
        step();
        check("lat_pulse_end", longint'(out_valid), 0);
        idle(2);

        // Extreme value
        burst(0, 0, 0, 0, -8192, -8192, 3, 1'b1);
        idle(4);
        check("ext_ovf",  longint'(ovf_err), 0);
        check("ext_frag", longint'(frag_err), 0);

        // Backpressure with a burst arriving during HOLD
        out_ready = 1'b0;
        burst(5, 5, 1, 2, -3, 7, 3, 1'b1);
        held = exp_q[exp_q.size()-1];
        idle(2);
        check("bp_hold_valid", longint'(out_valid), 1);
        send(100, 100);
        check("bp_valid_c1", longint'(out_valid), 1);
        check_outputs("bp_c1", held);
        send(-7, 9);
        check("bp_valid_c2", longint'(out_valid), 1);
        check_outputs("bp_c2", held);
        send(2, 2);
        check("bp_valid_c3", longint'(out_valid), 1);
        check_outputs("bp_c3", held);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_valid_idle", longint'(out_valid), 1);
            check_outputs("bp_idle", held);
        end
        check("bp_ovf", longint'(ovf_err), 1);
        out_ready = 1'b1;
        step();
        check("bp_after_accept", longint'(out_valid), 0);
        idle(4);
        check("bp_no_extra", longint'(out_valid), 0);

        // Fragment
        burst(9, 9, 8, 8, 0, 0, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            check("frag_no_valid", longint'(out_valid), 0);
        end
        check("frag_flag", longint'(frag_err), 1);
        burst(1, 1, 2, 2, 0, 1, 3, 1'b1);
        idle(4);

        // Reset mid-burst
        burst(6, 6, 7, 7, 0, 0, 2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_valid", longint'(out_valid), 0);
        check("mrst_idx",   longint'(peak_idx), 0);
        check("mrst_re",    longint'(peak_real), 0);
        check("mrst_im",    longint'(peak_image), 0);
        check("mrst_mag",   longint'(peak_mag), 0);
        check("mrst_sum",   longint'(sum_mag), 0);
        check("mrst_ovf",   longint'(ovf_err), 0);
        check("mrst_frag",  longint'(frag_err), 0);
        step();
        burst(0, 2, 0, -3, 1, 0, 3, 1'b1);
        idle(4);

        // Back-to-back: next burst starts on the acceptance edge
        out_ready = 1'b0;
        burst(-4, 3, 2, 6, 1, 1, 3, 1'b1);
        idle(2);
        check("b2b_hold", longint'(out_valid), 1);
        out_ready = 1'b1;
        burst(7, -7, -2, 10, 7, 7, 3, 1'b1);
        idle(4);
        check("b2b_ovf", longint'(ovf_err), 0);
        check("b2b_frag", longint'(frag_err), 0);

        // Random bursts
        for (int b = 0; b < 6; b++) begin
            burst(int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
                  int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
                  int'($urandom_range(16383)) - 8192, int'($urandom_range(16383)) - 8192,
                  3, 1'b1);
            idle(3);
        end
        idle(4);

        check("records_outstanding", longint'(exp_q.size()), 0);
        check("final_ovf", longint'(ovf_err), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
